exec_pipe: RTL and testbench

Parametrised decode/execute unit with an internal register file, ALU and multi-cycle multiplier. Accepts one 32-bit instruction per cycle over a valid/ready handshake, reads operands, executes and writes the result back to the register file. Sits between instruction fetch and the rest of the core and replaces the standalone ALU/regfile pairing as the execute stage.

---
 rtl/exec_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_exec_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_pipe.sv
// ============================================================================
// Module      : exec_pipe
// Description : Decode/execute stage with register file, single-cycle ALU and
//               shift-add multiplier. Define EXEC_PIPE_FORWARD_EN to bypass
//               completing results instead of stalling on a hazard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_pipe #(
  parameter int WIDTH = 32,
  parameter int REGS  = 16,
  localparam int AW   = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_zero,
  output logic             wb_carry,
  output logic             illegal,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_SHL = 8'h05;
  localparam logic [7:0] OP_SHR = 8'h06;
  localparam logic [7:0] OP_LDI = 8'h07;
  localparam logic [7:0] OP_MUL = 8'h08;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MULT = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rf [REGS];
  logic [7:0]       r_op;
  logic [AW-1:0]    r_rd;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;

  logic [7:0]       w_opc;
  logic [AW-1:0]    w_rd;
  logic [AW-1:0]    w_rs1;
  logic [AW-1:0]    w_rs2;
  logic [WIDTH-1:0] w_imm;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b_rf;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_mul_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_done;
  logic             w_illegal_op;
  logic             w_wr;
  logic             w_hazard;
  logic             w_accept;
  logic             w_unused_instr;

  assign w_opc  = in_instr[31:24];
  assign w_rd   = in_instr[16 +: AW];
  assign w_rs1  = in_instr[8 +: AW];
  assign w_rs2  = in_instr[0 +: AW];
  assign w_unused_instr = ^in_instr;

  generate
    if (WIDTH >= 16) begin : g_imm_wide
      assign w_imm = WIDTH'(in_instr[15:0]);
    end else begin : g_imm_narrow
      assign w_imm = in_instr[WIDTH-1:0];
    end
  endgenerate

  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
  // One partial product per cycle: r_a walks left, r_b walks right.
  assign w_mul_sum = r_acc + (r_b[0] ? r_a : '0);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (r_op)
      OP_ADD: begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
      OP_SUB: begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_SHL: w_res = r_a << r_b[SW-1:0];
      OP_SHR: w_res = r_a >> r_b[SW-1:0];
      OP_LDI: w_res = r_b;
      default: w_res = '0;
    endcase
    if (r_state == S_MULT) begin
      w_res = w_mul_sum;
    end
  end

  assign w_done       = ((r_state == S_EXEC) && (r_op != OP_MUL)) ||
                        ((r_state == S_MULT) && (r_cnt == CW'(1)));
  assign w_illegal_op = (r_op > OP_MUL);
  assign w_wr         = w_done && !w_illegal_op;

`ifdef EXEC_PIPE_FORWARD_EN
  assign w_hazard = 1'b0;
  assign w_a      = (w_wr && (w_rs1 == r_rd)) ? w_res : r_rf[w_rs1];
  assign w_b_rf   = (w_wr && (w_rs2 == r_rd)) ? w_res : r_rf[w_rs2];
`else
  assign w_hazard = w_wr && ((w_rs1 == r_rd) || (w_rs2 == r_rd));
  assign w_a      = r_rf[w_rs1];
  assign w_b_rf   = r_rf[w_rs2];
`endif

  assign w_b      = (w_opc == OP_LDI) ? w_imm : w_b_rf;
  assign in_ready = !rst && ((r_state == S_IDLE) || w_done) && !w_hazard;
  assign w_accept = in_valid && in_ready;
  assign dbg_data = r_rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wb_zero  <= 1'b0;
      wb_carry <= 1'b0;
      illegal  <= 1'b0;
      for (int i = 0; i < REGS; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      if (w_wr) begin
        r_rf[r_rd] <= w_res;
        wb_valid   <= 1'b1;
        wb_addr    <= r_rd;
        wb_data    <= w_res;
        wb_zero    <= (w_res == '0);
        wb_carry   <= w_carry;
      end
      if (w_done && w_illegal_op) begin
        illegal <= 1'b1;
      end

      case (r_state)
        S_EXEC: begin
          if (r_op == OP_MUL) begin
            r_state <= S_MULT;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MULT: begin
          r_acc <= w_mul_sum;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt - CW'(1);
          if (w_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A new accept overrides the retirement transition, overlapping stages.
      if (w_accept) begin
        r_state <= S_EXEC;
        r_op    <= w_opc;
        r_rd    <= w_rd;
        r_a     <= w_a;
        r_b     <= w_b;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_pipe.sv
// Testbench for exec_pipe: directed test-plan steps followed by random traffic,
// compared cycle by cycle against a transaction-level reference model.
`default_nettype none

module tb_exec_pipe;

  localparam int WIDTH = 32;
  localparam int REGS  = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             wb_zero;
  logic             wb_carry;
  logic             illegal;
  logic [AW-1:0]    dbg_addr = '0;
  logic [WIDTH-1:0] dbg_data;

  int n_cmp  = 0;
  int n_fail = 0;

  exec_pipe #(.WIDTH(WIDTH), .REGS(REGS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_zero(wb_zero), .wb_carry(wb_carry), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers plus the one in-flight instruction.
  logic [WIDTH-1:0] m_rf [REGS];
  bit               m_busy;
  int               m_left;
  int               m_rd;
  logic [WIDTH-1:0] m_res;
  bit               m_carry;
  bit               m_write;
  bit               e_wbv, e_ill, e_zero, e_carry;
  logic [AW-1:0]    e_addr;
  logic [WIDTH-1:0] e_data;
  bit               last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    bit r;
    if (rst) return 1'b0;
    r = !m_busy || (m_left == 1);
`ifndef EXEC_PIPE_FORWARD_EN
    if (m_busy && m_left == 1 && m_write &&
        ((int'(in_instr[15:8]) % REGS == m_rd) || (int'(in_instr[7:0]) % REGS == m_rd)))
      r = 1'b0;
`endif
    return r;
  endfunction

  task automatic model_issue(input logic [31:0] ins);
    longint unsigned a, b, r;
    a = 64'(m_rf[int'(ins[15:8]) % REGS]);
    b = 64'(m_rf[int'(ins[7:0]) % REGS]);
    m_busy  = 1'b1;
    m_left  = 1;
    m_write = 1'b1;
    m_carry = 1'b0;
    m_rd    = int'(ins[23:16]) % REGS;
    case (int'(ins[31:24]))
      0: begin r = a + b; m_carry = ((r >> WIDTH) & 1) != 0; end
      1: begin r = a - b; m_carry = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << (b % WIDTH);
      6: r = a >> (b % WIDTH);
      7: r = 64'(ins[15:0]);
      8: begin r = a * b; m_left = 1 + WIDTH; end
      default: begin r = 0; m_write = 1'b0; end
    endcase
    m_res = WIDTH'(r);
  endtask

  // One clock: check ready, advance the model at the edge, check outputs.
  task automatic cycle();
    bit acc;
    #1;
    chk("in_ready", in_ready, model_ready());
    acc = in_valid && model_ready();
    @(posedge clk);
    e_wbv = 1'b0;
    e_ill = 1'b0;
    if (rst) begin
      for (int i = 0; i < REGS; i++) m_rf[i] = '0;
      m_busy = 1'b0;
      e_addr = '0; e_data = '0; e_zero = 1'b0; e_carry = 1'b0;
    end else begin
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          if (m_write) begin
            m_rf[m_rd] = m_res;
            e_wbv = 1'b1; e_addr = AW'(m_rd); e_data = m_res;
            e_zero = (m_res == '0); e_carry = m_carry;
          end else begin
            e_ill = 1'b1;
          end
        end
      end
      if (acc) model_issue(in_instr);
    end
    last_acc = acc;
    @(negedge clk);
    chk("wb_valid", wb_valid, e_wbv);
    chk("illegal", illegal, e_ill);
    chk("wb_addr", wb_addr, e_addr);
    chk("wb_data", wb_data, e_data);
    if (e_wbv) begin
      chk("wb_zero", wb_zero, e_zero);
      chk("wb_carry", wb_carry, e_carry);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_instr = $urandom();
      cycle();
    end
  endtask

  task automatic send(input logic [31:0] ins, output int stalls);
    bit done;
    stalls   = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (last_acc) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $error("FAIL send_timeout observed=stalled expected=accept instr=%0h", ins);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < REGS; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk(tag, dbg_data, m_rf[i]);
    end
    @(negedge clk);
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [WIDTH-1:0] exp);
    dbg_addr = AW'(idx);
    #1;
    chk(tag, dbg_data, exp);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
    return {8'(op), 8'(rd), 8'(rs1), 8'(rs2)};
  endfunction

  function automatic logic [31:0] ldi(input int rd, input logic [15:0] imm);
    return {8'h07, 8'(rd), imm};
  endfunction

  initial begin
    int s;
    int exp_stall;
    logic [31:0] ins;
    int sel;

    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_regs("reset_rf");
    idle(1);

    // Dependent back-to-back chain
    send(ldi(1, 16'hFF00), s);
    send(ldi(2, 16'h00FF), s);
    send(mk(0, 3, 1, 2), s);
`ifdef EXEC_PIPE_FORWARD_EN
    exp_stall = 0;
`else
    exp_stall = 1;
`endif
    chk("add_stall", s, exp_stall);
    idle(1);
    chk("add_data", wb_data, 32'h0000FFFF);
    chk("add_carry", wb_carry, 1'b0);

    send(mk(1, 4, 2, 1), s);
    idle(1);
    chk("sub_data", wb_data, 32'hFFFF01FF);
    chk("sub_carry", wb_carry, 1'b1);
    chk("sub_zero", wb_zero, 1'b0);
    send(mk(4, 5, 1, 1), s);
    idle(1);
    chk("xor_zero", wb_zero, 1'b1);

    // Multiply: next instruction waits exactly WIDTH cycles, then overlaps
    send(mk(8, 6, 1, 2), s);
    send(ldi(7, 16'h0042), s);
    chk("mul_stall", s, WIDTH);
    idle(2);
    check_reg("mul_result", 6, 32'h00FE0100);

    // Undefined opcode
    send(mk(8'hFF, 9, 1, 2), s);
    idle(2);
    check_regs("illegal_rf");

    // Reset during a multiply
    send(mk(8, 6, 1, 2), s);
    idle(9);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    check_regs("mul_abort_rf");
    send(ldi(1, 16'h1234), s);
    idle(1);
    check_reg("ldi_after_reset", 1, 32'h00001234);

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      idle($urandom_range(0, 2));
      ins = $urandom();
      sel = $urandom_range(0, 19);
      if (sel < 14)      ins[31:24] = 8'(sel % 8);
      else if (sel < 17) ins[31:24] = 8'h08;
      else               ins[31:24] = 8'($urandom_range(9, 255));
      send(ins, s);
    end
    idle(40);
    check_regs("final_rf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
